// File: rtl/sdc_pkg.sv
// Shared FSM encoding and burst helpers for the SDR/DDR request front-end.
package sdc_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_WD = 2'd1;
  localparam logic [1:0] ST_REQ     = 2'd2;
  localparam logic [1:0] ST_BURST   = 2'd3;

  localparam int RD_PEND_MAX = 63;

  function automatic logic [3:0] len_to_beats(input logic [1:0] len);
    return 4'd1 << len;
  endfunction

endpackage

// File: rtl/sdc_sync_fifo.sv
// Show-ahead synchronous FIFO: head word visible on dout while not empty,
// count/full/empty are registered so ready paths stay short.
module sdc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop lands in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == CNT_LAST);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdc_req_queue.sv
// Host request front-end for the SDR/DDR controller: queues commands and write
// beats, issues them on the sdr_req handshake and returns read beats one cycle late.
module sdc_req_queue
  import sdc_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int WD_DEPTH  = 16
) (
  input  logic                  mclk,
  input  logic                  s_reset,
  input  logic                  hst_req_valid,
  output logic                  hst_req_ready,
  input  logic [ADDR_W-1:0]     hst_req_adr,
  input  logic [1:0]            hst_req_len,
  input  logic                  hst_req_wr_n,
  input  logic                  hst_wd_valid,
  output logic                  hst_wd_ready,
  input  logic [DATA_W-1:0]     hst_wd_data,
  input  logic [DATA_W/8-1:0]   hst_wd_mask_n,
  output logic                  hst_rd_valid,
  output logic [DATA_W-1:0]     hst_rd_data,
  output logic                  hst_err,
  output logic                  sdr_req,
  output logic [ADDR_W-1:0]     sdr_req_adr,
  output logic [1:0]            sdr_req_len,
  output logic                  sdr_req_wr_n,
  output logic [DATA_W-1:0]     sdr_wr_data,
  output logic [DATA_W/8-1:0]   sdr_wr_en_n,
  input  logic                  sdr_req_ack,
  input  logic                  sdr_wr_next,
  input  logic                  sdr_rd_valid,
  input  logic [DATA_W-1:0]     sdr_rd_data,
  input  logic                  sdr_init_done
);
  localparam int MASK_W = DATA_W / 8;
  localparam int CMD_W  = ADDR_W + 3;
  localparam int WD_W   = DATA_W + MASK_W;
  localparam int WD_CW  = $clog2(WD_DEPTH) + 1;

  logic [CMD_W-1:0]  cmd_head;
  logic              cmd_full, cmd_empty, cmd_pop;
  logic [WD_W-1:0]   wd_head;
  logic [WD_CW-1:0]  wd_count;
  logic              wd_full, wd_empty, wd_pop;
  logic [ADDR_W-1:0] head_adr;
  logic [1:0]        head_len;
  logic              head_wr_n;
  logic [3:0]        head_beats;
  logic [1:0]        state;
  logic [3:0]        wr_rem;
  logic [5:0]        rd_pend, rd_add;
  logic              ack_ok, next_ok, rd_err, rd_dec, wd_enough, rd_room, can_issue;

  sdc_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(mclk), .rst(s_reset), .push(hst_req_valid),
    .din({hst_req_adr, hst_req_len, hst_req_wr_n}), .pop(cmd_pop),
    .dout(cmd_head), .count(), .full(cmd_full), .empty(cmd_empty)
  );

  sdc_sync_fifo #(.WIDTH(WD_W), .DEPTH(WD_DEPTH)) u_wd_fifo (
    .clk(mclk), .rst(s_reset), .push(hst_wd_valid),
    .din({hst_wd_data, hst_wd_mask_n}), .pop(wd_pop),
    .dout(wd_head), .count(wd_count), .full(wd_full), .empty(wd_empty)
  );

  assign hst_req_ready = !cmd_full;
  assign hst_wd_ready  = !wd_full;
  assign sdr_wr_data   = wd_empty ? '0 : wd_head[WD_W-1:MASK_W];
  assign sdr_wr_en_n   = wd_empty ? '1 : wd_head[MASK_W-1:0];

  assign {head_adr, head_len, head_wr_n} = cmd_head;
  assign head_beats = len_to_beats(head_len);

  // Protocol violations are flagged and otherwise ignored: no pops, no state change.
  assign ack_ok    = sdr_req_ack && (state == ST_REQ);
  assign next_ok   = sdr_wr_next && (state == ST_BURST);
  assign cmd_pop   = ack_ok;
  assign wd_pop    = next_ok;
  assign wd_enough = int'(wd_count) >= int'(head_beats);
  assign rd_room   = (int'(rd_pend) + int'(head_beats)) <= RD_PEND_MAX;
  assign can_issue = sdr_init_done && !cmd_empty && (head_wr_n ? rd_room : wd_enough);
  assign rd_err    = sdr_rd_valid && (rd_pend == 6'd0);
  assign rd_dec    = sdr_rd_valid && !rd_err;
  assign rd_add    = (ack_ok && sdr_req_wr_n) ? {2'b00, len_to_beats(sdr_req_len)} : 6'd0;

  always_ff @(posedge mclk or posedge s_reset) begin
    if (s_reset) begin
      state        <= ST_IDLE;
      wr_rem       <= '0;
      rd_pend      <= '0;
      hst_err      <= 1'b0;
      hst_rd_valid <= 1'b0;
      hst_rd_data  <= '0;
      sdr_req      <= 1'b0;
      sdr_req_adr  <= '0;
      sdr_req_len  <= '0;
      sdr_req_wr_n <= 1'b0;
    end else begin
      hst_rd_valid <= sdr_rd_valid;
      hst_rd_data  <= sdr_rd_data;
      rd_pend      <= rd_pend + rd_add - {5'd0, rd_dec};
      if (rd_err || (sdr_wr_next && !next_ok) || (sdr_req_ack && !ack_ok))
        hst_err <= 1'b1;

      case (state)
        ST_IDLE, ST_WAIT_WD: begin
          if (can_issue) begin
            state        <= ST_REQ;
            sdr_req      <= 1'b1;
            sdr_req_adr  <= head_adr;
            sdr_req_len  <= head_len;
            sdr_req_wr_n <= head_wr_n;
          end else if (sdr_init_done && !cmd_empty && !head_wr_n) begin
            state <= ST_WAIT_WD;
          end
        end
        ST_REQ: begin
          if (ack_ok) begin
            sdr_req <= 1'b0;
            if (!sdr_req_wr_n) begin
              state  <= ST_BURST;
              wr_rem <= len_to_beats(sdr_req_len);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_BURST: begin
          if (next_ok) begin
            wr_rem <= wr_rem - 1'b1;
            if (wr_rem == 4'd1) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_req_queue.sv
// Self-checking bench for sdc_req_queue: the bench plays host and controller
// and checks the DUT against queue-based models of commands, write beats and read credit.
module tb_sdc_req_queue;
  import sdc_pkg::*;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int MW     = DATA_W / 8;

  logic              mclk = 1'b0;
  logic              s_reset;
  logic              hst_req_valid, hst_req_ready, hst_req_wr_n;
  logic [ADDR_W-1:0] hst_req_adr;
  logic [1:0]        hst_req_len;
  logic              hst_wd_valid, hst_wd_ready;
  logic [DATA_W-1:0] hst_wd_data;
  logic [MW-1:0]     hst_wd_mask_n;
  logic              hst_rd_valid, hst_err;
  logic [DATA_W-1:0] hst_rd_data;
  logic              sdr_req, sdr_req_wr_n;
  logic [ADDR_W-1:0] sdr_req_adr;
  logic [1:0]        sdr_req_len;
  logic [DATA_W-1:0] sdr_wr_data;
  logic [MW-1:0]     sdr_wr_en_n;
  logic              sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_init_done;
  logic [DATA_W-1:0] sdr_rd_data;

  always #5 mclk = ~mclk;

  sdc_req_queue dut (
    .mclk(mclk), .s_reset(s_reset),
    .hst_req_valid(hst_req_valid), .hst_req_ready(hst_req_ready),
    .hst_req_adr(hst_req_adr), .hst_req_len(hst_req_len), .hst_req_wr_n(hst_req_wr_n),
    .hst_wd_valid(hst_wd_valid), .hst_wd_ready(hst_wd_ready),
    .hst_wd_data(hst_wd_data), .hst_wd_mask_n(hst_wd_mask_n),
    .hst_rd_valid(hst_rd_valid), .hst_rd_data(hst_rd_data), .hst_err(hst_err),
    .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
    .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
    .sdr_req_ack(sdr_req_ack), .sdr_wr_next(sdr_wr_next),
    .sdr_rd_valid(sdr_rd_valid), .sdr_rd_data(sdr_rd_data), .sdr_init_done(sdr_init_done)
  );

  typedef struct {
    logic [ADDR_W-1:0] adr;
    logic [1:0]        len;
    logic              wr_n;
  } cmd_t;

  cmd_t                 mq_cmd[$];
  logic [DATA_W+MW-1:0] mq_wd[$];
  int                   m_pend;
  int                   vec_cnt = 0;
  int                   err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge mclk);
  endtask

  task automatic clear_inputs();
    hst_req_valid = 0; hst_req_adr = '0; hst_req_len = '0; hst_req_wr_n = 0;
    hst_wd_valid = 0;  hst_wd_data = '0; hst_wd_mask_n = '0;
    sdr_req_ack = 0;   sdr_wr_next = 0; sdr_rd_valid = 0; sdr_rd_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    s_reset = 1;
    tick(); tick();
    s_reset = 0;
    tick();
    mq_cmd.delete(); mq_wd.delete(); m_pend = 0;
  endtask

  task automatic push_cmd(input logic [ADDR_W-1:0] a, input logic [1:0] l, input logic w);
    cmd_t c;
    int n = 0;
    while (!hst_req_ready && n < 200) begin tick(); n++; end
    if (!hst_req_ready) begin check("cmd_ready_timeout", 0, 1); return; end
    hst_req_valid = 1; hst_req_adr = a; hst_req_len = l; hst_req_wr_n = w;
    tick();
    hst_req_valid = 0;
    c.adr = a; c.len = l; c.wr_n = w;
    mq_cmd.push_back(c);
  endtask

  task automatic push_wd();
    logic [DATA_W-1:0] d;
    logic [MW-1:0]     m;
    int n = 0;
    d = $urandom; m = MW'($urandom);
    while (!hst_wd_ready && n < 200) begin tick(); n++; end
    if (!hst_wd_ready) begin check("wd_ready_timeout", 0, 1); return; end
    hst_wd_valid = 1; hst_wd_data = d; hst_wd_mask_n = m;
    tick();
    hst_wd_valid = 0;
    mq_wd.push_back({d, m});
  endtask

  // Waits (bounded) for a request and compares it against the oldest modelled command.
  task automatic wait_req(output bit ok, output cmd_t c);
    int n = 0;
    ok = 0;
    c.adr = '0; c.len = '0; c.wr_n = 0;
    while (!sdr_req && n < 100) begin tick(); n++; end
    if (!sdr_req) begin check("req_timeout", 0, 1); return; end
    if (mq_cmd.size() == 0) begin check("req_unexpected", 1, 0); return; end
    c = mq_cmd.pop_front();
    check("req_adr", sdr_req_adr, c.adr);
    check("req_len", sdr_req_len, c.len);
    check("req_wr_n", sdr_req_wr_n, c.wr_n);
    ok = 1;
  endtask

  task automatic write_beats(input int n);
    for (int b = 0; b < n; b++) begin
      if ($urandom_range(0, 2) == 0) tick();
      if (mq_wd.size() == 0) begin check("wd_model_empty", 1, 0); return; end
      check("wr_beat", {sdr_wr_data, sdr_wr_en_n}, mq_wd.pop_front());
      sdr_wr_next = 1;
      tick();
      sdr_wr_next = 0;
    end
  endtask

  task automatic serve_one(input int hold);
    cmd_t c;
    bit   ok;
    wait_req(ok, c);
    if (!ok) return;
    repeat (hold) begin
      tick();
      check("req_hold", {sdr_req, sdr_req_adr, sdr_req_len}, {1'b1, c.adr, c.len});
    end
    sdr_req_ack = 1;
    tick();
    sdr_req_ack = 0;
    check("req_drop", sdr_req, 0);
    if (!c.wr_n) write_beats(1 << c.len);
    else m_pend += (1 << c.len);
  endtask

  task automatic rd_return(input int n);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      sdr_rd_valid = 1; sdr_rd_data = d;
      tick();
      sdr_rd_valid = 0;
      check("rd_valid", hst_rd_valid, 1);
      check("rd_data", hst_rd_data, d);
      m_pend--;
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("rd_idle", hst_rd_valid, 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c;
    bit   ok;
    logic [DATA_W-1:0] d;
    logic [DATA_W+MW-1:0] w;

    clear_inputs();
    sdr_init_done = 1;
    s_reset = 1;
    m_pend = 0;
    tick(); tick();
    check("rst_req", sdr_req, 0);
    check("rst_rd_valid", hst_rd_valid, 0);
    check("rst_err", hst_err, 0);
    check("rst_wr_data", sdr_wr_data, 0);
    check("rst_wr_en_n", sdr_wr_en_n, {MW{1'b1}});
    check("rst_adr", {sdr_req_adr, sdr_req_len}, 0);
    check("rst_ready", {hst_req_ready, hst_wd_ready}, 2'b11);
    s_reset = 0;
    tick();

    // Read of 4 beats and its return path.
    push_cmd(24'h000100, 2'd2, 1'b1);
    serve_one(2);
    check("rd_pend_4", dut.rd_pend, m_pend);
    rd_return(4);
    check("rd_pend_0", dut.rd_pend, m_pend);
    check("err_after_read", hst_err, 0);

    // Write of 8 beats must wait until all 8 are queued.
    push_cmd(ADDR_W'($urandom), 2'd3, 1'b0);
    repeat (5) push_wd();
    repeat (6) begin tick(); check("wait_wd_no_req", sdr_req, 0); end
    repeat (3) push_wd();
    serve_one(1);
    check("wd_empty_data", sdr_wr_data, 0);
    check("wd_empty_mask", sdr_wr_en_n, {MW{1'b1}});

    // Commands pile up while the controller is not initialised.
    sdr_init_done = 0;
    for (int i = 0; i < 4; i++) push_cmd(ADDR_W'($urandom), 2'($urandom_range(0, 1)), 1'b1);
    check("cmd_full_ready", hst_req_ready, 0);
    hst_req_valid = 1; hst_req_adr = 24'hBADBAD; hst_req_len = 2'd0; hst_req_wr_n = 1;
    tick();
    hst_req_valid = 0;
    repeat (4) begin tick(); check("no_issue_uninit", sdr_req, 0); end
    sdr_init_done = 1;
    for (int i = 0; i < 4; i++) serve_one($urandom_range(0, 2));
    repeat (4) begin tick(); check("no_push_on_full", sdr_req, 0); end
    rd_return(m_pend);

    // Ack and read beat in the same cycle.
    push_cmd(ADDR_W'($urandom), 2'd1, 1'b1);
    serve_one(0);
    check("rd_pend_2", dut.rd_pend, m_pend);
    push_cmd(ADDR_W'($urandom), 2'd1, 1'b1);
    wait_req(ok, c);
    d = $urandom;
    sdr_req_ack = 1; sdr_rd_valid = 1; sdr_rd_data = d;
    tick();
    sdr_req_ack = 0; sdr_rd_valid = 0;
    m_pend = m_pend + 2 - 1;
    check("ack_rd_data", {hst_rd_valid, hst_rd_data}, {1'b1, d});
    check("rd_pend_3", dut.rd_pend, m_pend);
    rd_return(m_pend);

    // Read credit limit of 63 outstanding beats.
    for (int i = 0; i < 7; i++) begin push_cmd(ADDR_W'($urandom), 2'd3, 1'b1); serve_one(0); end
    push_cmd(ADDR_W'($urandom), 2'd2, 1'b1);
    serve_one(0);
    push_cmd(ADDR_W'($urandom), 2'd2, 1'b1);
    repeat (5) begin tick(); check("pend_limit_hold", sdr_req, 0); end
    rd_return(1);
    serve_one(0);
    check("rd_pend_63", dut.rd_pend, m_pend);
    rd_return(m_pend);

    // Protocol errors.
    check("err_clear", hst_err, 0);
    sdr_rd_valid = 1; tick(); sdr_rd_valid = 0; tick();
    check("err_rd_no_pend", hst_err, 1);
    check("rd_pend_stays_0", dut.rd_pend, 0);
    do_reset();
    check("err_reset", hst_err, 0);
    push_wd();
    w = mq_wd[0];
    sdr_wr_next = 1; tick(); sdr_wr_next = 0; tick();
    check("err_wr_next_idle", hst_err, 1);
    check("wd_no_pop", {sdr_wr_data, sdr_wr_en_n}, w);
    do_reset();
    sdr_req_ack = 1; tick(); sdr_req_ack = 0; tick();
    check("err_ack_idle", hst_err, 1);
    do_reset();

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      logic [1:0] l;
      logic       wn;
      l = 2'($urandom_range(0, 3));
      wn = 1'($urandom_range(0, 1));
      if (!wn && $urandom_range(0, 1) == 1) begin
        repeat (1 << l) push_wd();
        push_cmd(ADDR_W'($urandom), l, wn);
      end else begin
        push_cmd(ADDR_W'($urandom), l, wn);
        if (!wn) repeat (1 << l) push_wd();
      end
      serve_one($urandom_range(0, 3));
      if (wn && ($urandom_range(0, 1) == 1 || m_pend > 40)) rd_return(m_pend);
    end
    rd_return(m_pend);
    check("rand_pend", dut.rd_pend, 0);
    check("rand_err", hst_err, 0);

    // Reset in the middle of a write burst.
    push_cmd(ADDR_W'($urandom), 2'd3, 1'b0);
    repeat (8) push_wd();
    wait_req(ok, c);
    sdr_req_ack = 1; tick(); sdr_req_ack = 0;
    write_beats(3);
    s_reset = 1;
    #1;
    check("mid_rst_req", sdr_req, 0);
    check("mid_rst_wr", {sdr_wr_data, sdr_wr_en_n}, {{DATA_W{1'b0}}, {MW{1'b1}}});
    check("mid_rst_rd", {hst_rd_valid, hst_err}, 0);
    tick();
    s_reset = 0;
    mq_cmd.delete(); mq_wd.delete(); m_pend = 0;
    tick();
    check("post_rst_ready", {hst_req_ready, hst_wd_ready}, 2'b11);
    check("post_rst_wd_empty", sdr_wr_en_n, {MW{1'b1}});
    push_cmd(ADDR_W'($urandom), 2'd0, 1'b1);
    serve_one(0);
    rd_return(1);
    check("post_rst_err", hst_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
